// File: rtl/fbuf_pkg.sv
// Shared types for the double-buffered frame buffer: clear-engine states and bank index.
package fbuf_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    typedef logic bank_sel_t;

    function automatic bank_sel_t back_of(input bank_sel_t front);
        return ~front;
    endfunction

endpackage

// File: rtl/fbuf_bank_ram.sv
// One frame-buffer bank: simple dual-port RAM, 1-cycle registered read, no backpressure.
// Reset clears only the read register; stored words are never touched by reset.
module fbuf_bank_ram
    import fbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr_w] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dout <= '0;
        end else begin
            r_dout <= r_mem[i_addr_r];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/framebuf_dbl_ram.sv
// Double-buffered frame RAM: writer fills the back bank, scan reads the front bank (1-cycle read);
// swaps commit only on frame_start. Optional back-bank clear engine under FBUF_CLEAR_EN (holds off writes/swaps).
module framebuf_dbl_ram
    import fbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_dout,
    input  logic                  i_swap_req,
    input  logic                  i_frame_start,
    output logic                  o_swap_done,
    output logic                  o_front_sel,
    input  logic                  i_clr_start,
    input  logic [DATA_WIDTH-1:0] i_clr_value,
    output logic                  o_clr_busy,
    output logic                  o_clr_done
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    bank_sel_t             r_front_sel;
    bank_sel_t             r_rd_sel;
    logic                  r_pending;
    logic                  r_swap_done;

    logic                  w_clr_busy;
    logic                  w_clr_done;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic [DATA_WIDTH-1:0] w_clr_dat;
    bank_sel_t             w_clr_bank;

    logic                  w_wr_ready;
    logic                  w_pix_we;
    bank_sel_t             w_back;
    logic                  w_swap_commit;
    logic [ADDR_WIDTH-1:0] w_bank_addr_w;
    logic [DATA_WIDTH-1:0] w_bank_din;
    logic                  w_we0;
    logic                  w_we1;
    logic [DATA_WIDTH-1:0] w_dout0;
    logic [DATA_WIDTH-1:0] w_dout1;

`ifdef FBUF_CLEAR_EN
    clr_state_t            r_clr_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_clr_val;
    bank_sel_t             r_clr_bank;
    logic                  r_clr_busy;
    logic                  r_clr_done;

    // Target bank is frozen at start; swaps are held off while running so it stays the back bank.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_state <= CLR_IDLE;
            r_clr_cnt   <= '0;
            r_clr_val   <= '0;
            r_clr_bank  <= 1'b0;
            r_clr_busy  <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_clr_state)
                CLR_IDLE: begin
                    if (i_clr_start) begin
                        r_clr_state <= CLR_RUN;
                        r_clr_busy  <= 1'b1;
                        r_clr_cnt   <= '0;
                        r_clr_val   <= i_clr_value;
                        r_clr_bank  <= back_of(r_front_sel);
                    end
                end
                CLR_RUN: begin
                    r_clr_cnt <= r_clr_cnt + CNT_ONE;
                    if (r_clr_cnt == '1) begin
                        r_clr_state <= CLR_IDLE;
                        r_clr_busy  <= 1'b0;
                        r_clr_done  <= 1'b1;
                    end
                end
                default: r_clr_state <= CLR_IDLE;
            endcase
        end
    end

    assign w_clr_busy = r_clr_busy;
    assign w_clr_done = r_clr_done;
    assign w_clr_we   = (r_clr_state == CLR_RUN);
    assign w_clr_addr = r_clr_cnt;
    assign w_clr_dat  = r_clr_val;
    assign w_clr_bank = r_clr_bank;
`else
    logic w_unused_clr;
    assign w_unused_clr = ^{i_clr_start, i_clr_value};
    assign w_clr_busy   = 1'b0;
    assign w_clr_done   = 1'b0;
    assign w_clr_we     = 1'b0;
    assign w_clr_addr   = '0;
    assign w_clr_dat    = '0;
    assign w_clr_bank   = 1'b0;
`endif

    assign w_wr_ready    = ~w_clr_busy;
    assign w_pix_we      = i_we && w_wr_ready;
    assign w_back        = back_of(r_front_sel);
    assign w_swap_commit = i_frame_start && (r_pending || i_swap_req) && !w_clr_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_front_sel <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_pending   <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            // Remember which bank this cycle's read went to, so a swap on the same edge cannot mis-steer dout.
            r_rd_sel    <= r_front_sel;
            r_swap_done <= w_swap_commit;
            if (w_swap_commit) begin
                r_front_sel <= ~r_front_sel;
                r_pending   <= 1'b0;
            end else if (i_swap_req) begin
                r_pending   <= 1'b1;
            end
        end
    end

    // Clear engine and pixel writer are mutually exclusive: wr_ready is low for the whole clear.
    assign w_bank_addr_w = w_clr_we ? w_clr_addr : i_addr_w;
    assign w_bank_din    = w_clr_we ? w_clr_dat  : i_din;
    assign w_we0 = (w_clr_we && (w_clr_bank == 1'b0)) || (w_pix_we && (w_back == 1'b0));
    assign w_we1 = (w_clr_we && (w_clr_bank == 1'b1)) || (w_pix_we && (w_back == 1'b1));

    fbuf_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank0 (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (w_we0),
        .i_addr_w (w_bank_addr_w),
        .i_din    (w_bank_din),
        .i_addr_r (i_addr_r),
        .o_dout   (w_dout0)
    );

    fbuf_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank1 (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (w_we1),
        .i_addr_w (w_bank_addr_w),
        .i_din    (w_bank_din),
        .i_addr_r (i_addr_r),
        .o_dout   (w_dout1)
    );

    assign o_dout      = r_rd_sel ? w_dout1 : w_dout0;
    assign o_wr_ready  = w_wr_ready;
    assign o_swap_done = r_swap_done;
    assign o_front_sel = r_front_sel;
    assign o_clr_busy  = w_clr_busy;
    assign o_clr_done  = w_clr_done;

endmodule

// File: tb/tb_framebuf_dbl_ram.sv
// Randomized self-checking bench for framebuf_dbl_ram against an array-based two-bank model.
module tb_framebuf_dbl_ram;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_we;
    logic [AW-1:0] i_addr_w;
    logic [DW-1:0] i_din;
    logic          o_wr_ready;
    logic [AW-1:0] i_addr_r;
    logic [DW-1:0] o_dout;
    logic          i_swap_req;
    logic          i_frame_start;
    logic          o_swap_done;
    logic          o_front_sel;
    logic          i_clr_start;
    logic [DW-1:0] i_clr_value;
    logic          o_clr_busy;
    logic          o_clr_done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] m_mem [2][DEPTH];
    logic          m_front;
    logic          m_pend;
    logic          m_busy;

    always #5 clk = ~clk;

    framebuf_dbl_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_we          (i_we),
        .i_addr_w      (i_addr_w),
        .i_din         (i_din),
        .o_wr_ready    (o_wr_ready),
        .i_addr_r      (i_addr_r),
        .o_dout        (o_dout),
        .i_swap_req    (i_swap_req),
        .i_frame_start (i_frame_start),
        .o_swap_done   (o_swap_done),
        .o_front_sel   (o_front_sel),
        .i_clr_start   (i_clr_start),
        .i_clr_value   (i_clr_value),
        .o_clr_busy    (o_clr_busy),
        .o_clr_done    (o_clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: the model predicts the read from the front bank before the edge,
    // applies the back-bank write, then decides whether a swap commits on this frame tick.
    task automatic step(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] d,
                        input logic [AW-1:0] ar, input logic sreq, input logic fs);
        logic [DW-1:0] exp_d;
        logic          commit;
        i_we          = we;
        i_addr_w      = aw;
        i_din         = d;
        i_addr_r      = ar;
        i_swap_req    = sreq;
        i_frame_start = fs;
        exp_d  = m_mem[m_front][ar];
        if (we && !m_busy) m_mem[!m_front][aw] = d;
        commit = fs && (m_pend || sreq) && !m_busy;
        if (commit) begin
            m_front = !m_front;
            m_pend  = 1'b0;
        end else if (sreq) begin
            m_pend = 1'b1;
        end
        tick();
        i_we          = 1'b0;
        i_swap_req    = 1'b0;
        i_frame_start = 1'b0;
        chk("dout", 32'(o_dout), 32'(exp_d));
        chk("front_sel", 32'(o_front_sel), 32'(m_front));
        chk("swap_done", 32'(o_swap_done), 32'(commit));
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, AW'(a), 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, 32'(o_dout), 32'h0);
        chk({tag, "_wr_ready"}, 32'(o_wr_ready), 32'h1);
        chk({tag, "_front_sel"}, 32'(o_front_sel), 32'h0);
        chk({tag, "_clr_busy"}, 32'(o_clr_busy), 32'h0);
        chk({tag, "_clr_done"}, 32'(o_clr_done), 32'h0);
        chk({tag, "_swap_done"}, 32'(o_swap_done), 32'h0);
    endtask

    initial begin
        logic       saved_front;
        logic       tgt;
        logic [DW-1:0] d;

        i_reset = 1'b1; i_we = 1'b0; i_addr_w = '0; i_din = '0; i_addr_r = '0;
        i_swap_req = 1'b0; i_frame_start = 1'b0; i_clr_start = 1'b0; i_clr_value = '0;
        tick();
        tick();
        check_reset_state("reset");
        i_reset = 1'b0;
        m_front = 1'b0; m_pend = 1'b0; m_busy = 1'b0;

        // Give both banks known contents: fill back, swap, fill the other back, swap.
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                d = DW'($urandom);
                i_we = 1'b1; i_addr_w = AW'(a); i_din = d;
                tick();
                m_mem[!m_front][a] = d;
            end
            i_we = 1'b0; i_swap_req = 1'b1; i_frame_start = 1'b1;
            tick();
            i_swap_req = 1'b0; i_frame_start = 1'b0;
            m_front = !m_front;
            chk("init_swap_front", 32'(o_front_sel), 32'(m_front));
            chk("init_swap_done", 32'(o_swap_done), 32'h1);
        end

        // Write lands in the back bank; only visible after a swap.
        step(1'b1, AW'(5), 8'hA5, AW'(5), 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, AW'(5), 1'b0, 1'b0);
        chk("a5_visible", 32'(o_dout), 32'hA5);
        chk("a5_front", 32'(o_front_sel), 32'h1);

        // Several requests without a frame tick collapse into a single swap.
        saved_front = m_front;
        for (int i = 0; i < 100; i++)
            step(1'b1, AW'($urandom), DW'($urandom), AW'($urandom),
                 (i == 10) || (i == 40) || (i == 70), 1'b0);
        chk("no_swap_without_frame", 32'(o_front_sel), 32'(saved_front));
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("one_toggle", 32'(o_front_sel), 32'(!saved_front));
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, AW'($urandom), 1'b0, 1'b1);
        chk("still_one_toggle", 32'(o_front_sel), 32'(!saved_front));

        for (int i = 0; i < 400; i++)
            step(1'(($urandom % 2) == 0), AW'($urandom), DW'($urandom), AW'($urandom),
                 1'(($urandom % 8) == 0), 1'(($urandom % 12) == 0));

        // Reset mid-run: state returns to defaults, pending swap dropped, RAM preserved.
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("midrun_reset");
        m_front = 1'b0; m_pend = 1'b0;
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        read_all();

`ifdef FBUF_CLEAR_EN
        // Clear the back bank; writes and swaps are held off until it finishes.
        tgt = !m_front;
        i_clr_start = 1'b1; i_clr_value = 8'h3C;
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        i_clr_start = 1'b0; i_clr_value = DW'($urandom);
        m_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("clr_busy_run", 32'(o_clr_busy), 32'h1);
            chk("wr_ready_run", 32'(o_wr_ready), 32'h0);
            chk("clr_done_run", 32'(o_clr_done), 32'h0);
            i_clr_start = (i == 5);
            step(1'b1, AW'($urandom), DW'($urandom), AW'($urandom), i == 3, i == 8);
            i_clr_start = 1'b0;
        end
        m_busy = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_mem[tgt][a] = 8'h3C;
        chk("clr_busy_end", 32'(o_clr_busy), 32'h0);
        chk("clr_done_pulse", 32'(o_clr_done), 32'h1);
        chk("wr_ready_end", 32'(o_wr_ready), 32'h1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("clr_done_low", 32'(o_clr_done), 32'h0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("deferred_swap", 32'(o_front_sel), 32'(tgt));
        read_all();

        // Reset on the 7th clear cycle leaves words 0..6 filled, the rest untouched.
        tgt = !m_front;
        for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), DW'($urandom), '0, 1'b0, 1'b0);
        i_clr_start = 1'b1; i_clr_value = 8'h5A;
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        i_clr_start = 1'b0;
        m_busy = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("clr_abort");
        m_busy = 1'b0; m_front = 1'b0; m_pend = 1'b0;
        for (int a = 0; a < 7; a++) m_mem[tgt][a] = 8'h5A;
        if (tgt != m_front) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        read_all();
`else
        // Without the clear engine the clear inputs must have no effect.
        i_clr_start = 1'b1; i_clr_value = DW'($urandom);
        step(1'b1, AW'(3), 8'h77, '0, 1'b0, 1'b0);
        i_clr_start = 1'b0;
        chk("noclr_busy", 32'(o_clr_busy), 32'h0);
        chk("noclr_wr_ready", 32'(o_wr_ready), 32'h1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("noclr_done", 32'(o_clr_done), 32'h0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, AW'(3), 1'b0, 1'b0);
        chk("noclr_write_kept", 32'(o_dout), 32'h77);
        read_all();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuf_dbl_ram.md
# framebuf_dbl_ram

Double-buffered frame-buffer RAM: two banks of 2**ADDR_WIDTH words, pixel writer fills the back bank while the video scan reads the front bank. Bank swap is requested at any time and committed only on a frame boundary, so the display never tears. An optional clear engine fills the back bank with a constant. Sits between the game-logic pixel writer and the VGA pixel-generation path, replacing a single-bank frame-buffer RAM.

## Interface
- ADDR_WIDTH, 10, address bits per bank; depth 2**ADDR_WIDTH.
- DATA_WIDTH, 8, bits per pixel word.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write strobe, back bank.
- addr_w  in  ADDR_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- wr_ready  out  1  high when writes are accepted.
- addr_r  in  ADDR_WIDTH  read address, front bank.
- dout  out  DATA_WIDTH  registered read data.
- swap_req  in  1  one-cycle request to exchange banks.
- frame_start  in  1  one-cycle frame-boundary tick (vsync).
- swap_done  out  1  one-cycle pulse after a swap commits.
- front_sel  out  1  index of the current front bank.
- clr_start  in  1  one-cycle request to clear the back bank.
- clr_value  in  DATA_WIDTH  fill value, sampled with clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear finishes.

## Operation
- Reset values: front_sel=0, dout=0, wr_ready=1, swap_done=0, clr_busy=0, clr_done=0, swap-pending flag=0, clear FSM=CLR_IDLE. Reset does not alter memory contents.
- Write: when we && wr_ready, bank[~front_sel][addr_w] <= din. If we is high while wr_ready=0, the write is dropped.
- Read: dout <= bank[front_sel][addr_r], using front_sel as it stands in the cycle addr_r is sampled.
- Swap: swap_req sets pending. Swap commits on the edge where frame_start=1, (pending || swap_req)=1, and clr_busy=0. On commit, front_sel toggles, pending clears, and swap_done=1 for the next cycle. Repeated swap_req while pending is absorbed (one swap only). If frame_start arrives while clr_busy=1, pending is held until the first frame_start after the clear ends.
- Clear FSM: CLR_IDLE -> CLR_RUN on clr_start. On entry, latch clr_value and target bank ~front_sel, and clear the counter to 0. In CLR_RUN, write the latched value to bank[target][count] and increment count every cycle. After the write at count = all-ones, go to CLR_IDLE and pulse clr_done. clr_start while running is ignored. wr_ready = ~clr_busy.
- Counter is ADDR_WIDTH bits, and the terminal test is count == '1. Wrap is never reached.
- Reset mid-clear aborts immediately: words already written keep the fill value, the rest are unchanged.

## Timing
- Read latency: 1 cycle (addr_r at edge N, dout valid after edge N+1).
- Write to back bank becomes visible on dout one swap later; same-bank read/write collision cannot occur.
- Swap: frame_start at edge N -> front_sel changes after N; swap_done high during cycle N+1. A read issued at edge N uses the old front bank.
- Clear: clr_start at edge N -> clr_busy=1 from cycle N+1 for exactly 2**ADDR_WIDTH cycles. clr_done is high in the first cycle with clr_busy=0.

## Configuration
- FBUF_CLEAR_EN defined: clear engine present as above.
- FBUF_CLEAR_EN undefined: clear FSM removed; clr_busy, clr_done tied 0; wr_ready tied 1; clr_start, clr_value ignored; swaps are never deferred.

## Structure
- Package fbuf_pkg: clear-state enum (CLR_IDLE, CLR_RUN) and a bank-select typedef.
- Sub-module fbuf_bank_ram: simple dual-port RAM with separate read/write addresses and registered read. Instantiate it twice. The top level muxes the write port (pixel writer vs clear engine) and selects dout by the registered front_sel.

## Test plan
- Reset -> dout=0, wr_ready=1, front_sel=0, clr_busy=0, swap_done=0.
- Write 0xA5 to addr 5; read addr 5 returns prior front content. Then swap_req followed by frame_start -> swap_done pulse, front_sel=1, and a read of addr 5 returns 0xA5 one cycle later.
- swap_req pulsed 3 times over 100 cycles with no frame_start -> front_sel unchanged. One frame_start -> exactly one toggle and one swap_done.
- ADDR_WIDTH=4, clr_start with clr_value=0x3C -> clr_busy for 16 cycles, wr_ready=0, concurrent we dropped, then clr_done. After a swap, all 16 addresses read 0x3C.
- Pending swap with frame_start during clr_busy -> no swap. Next frame_start after clr_done -> swap commits.
- reset asserted on the 7th clear cycle -> clr_busy=0 next cycle. After a swap, addresses 0–6 read the fill value and 7–15 hold their old data.
